// File: rtl/mcm_pkg.sv
// -----------------------------------------------------------------------------
// mcm_pkg
// Shared types and helpers for the sequenced multiple-constant multiplier.
//   state_e  : scheduler FSM states (IDLE, RUN, DONE)
//   CIW      : width of the constant index (selects C0, C1 or C2)
//   shw_for  : bit-index width needed to address CW constant bits
//   SHW      : bit-index width for the default CW of 8
// -----------------------------------------------------------------------------
package mcm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CIW = 2;

  // A single-bit constant still needs a one-bit index register.
  function automatic int shw_for(input int cw);
    return (cw > 1) ? $clog2(cw) : 1;
  endfunction

  localparam int SHW = shw_for(8);

endpackage

// File: rtl/mcm_shift_add.sv
// -----------------------------------------------------------------------------
// mcm_shift_add
// The single shared shift-add datapath: acc_o = acc_i + (x_i << sh_i), mod 2^W.
// Ports:
//   acc_i [W-1:0]  running accumulator of the constant being scanned
//   x_i   [W-1:0]  captured multiplicand
//   sh_i  [SW-1:0] bit position of the current constant bit
//   acc_o [W-1:0]  updated accumulator (bits shifted past W-1 are dropped)
// -----------------------------------------------------------------------------
module mcm_shift_add
  import mcm_pkg::*;
#(
  parameter int W  = 32,
  parameter int SW = SHW
) (
  input  logic [W-1:0]  acc_i,
  input  logic [W-1:0]  x_i,
  input  logic [SW-1:0] sh_i,
  output logic [W-1:0]  acc_o
);

  // The shift is evaluated at width W, so overflow bits fall off naturally.
  assign acc_o = acc_i + (x_i << sh_i);

endmodule

// File: rtl/mcm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mcm_seq_ctrl
// Sequenced multiple-constant multiplier: y = C0*x, z = C1*x, w = C2*x
// (all mod 2^W) using one shared shift-add unit, one partial product per cycle.
// Constants are scanned LSB-first, in order C0, C1, C2.
//
// Configuration macro:
//   MCM_SKIP_ZERO_EN  defined   : RUN visits only set constant bits
//                     undefined : fixed full scan of 3*CW RUN cycles
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (aborts any transaction)
//   in_valid   x is valid          in_ready   block can accept x (IDLE only)
//   x [W-1:0]  multiplicand, sampled only on the accept edge
//   out_valid  y/z/w are valid     out_ready  consumer accepts results
//   y/z/w      C0*x, C1*x, C2*x mod 2^W
//   busy       FSM is not in IDLE
// -----------------------------------------------------------------------------
module mcm_seq_ctrl
  import mcm_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 8,
  parameter int C0 = 9,
  parameter int C1 = 23,
  parameter int C2 = 81
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [W-1:0] z,
  output logic [W-1:0] w,
  output logic         busy
);

  localparam int SW = shw_for(CW);

  localparam logic [CW-1:0] K0 = CW'(C0);
  localparam logic [CW-1:0] K1 = CW'(C1);
  localparam logic [CW-1:0] K2 = CW'(C2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q,     state_d;
  logic [W-1:0]    xr_q,        xr_d;
  logic [CIW-1:0]  ci_q,        ci_d;
  logic [SW-1:0]   bi_q,        bi_d;
  logic [W-1:0]    y_q,         y_d;
  logic [W-1:0]    z_q,         z_d;
  logic [W-1:0]    w_q,         w_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q,  in_ready_d;
  logic            busy_q,      busy_d;

  // ---------------------------------------------------------------------------
  // Shared datapath: select the accumulator and constant addressed by ci.
  // ---------------------------------------------------------------------------
  logic [W-1:0]  acc_sel;
  logic [W-1:0]  acc_sum;
  logic [CW-1:0] c_sel;
  logic          bit_set;

  always_comb begin
    case (ci_q)
      2'd0:    begin acc_sel = y_q; c_sel = K0; end
      2'd1:    begin acc_sel = z_q; c_sel = K1; end
      default: begin acc_sel = w_q; c_sel = K2; end
    endcase
  end

  assign bit_set = c_sel[bi_q];

  mcm_shift_add #(
    .W  (W),
    .SW (SW)
  ) u_shift_add (
    .acc_i (acc_sel),
    .x_i   (xr_q),
    .sh_i  (bi_q),
    .acc_o (acc_sum)
  );

`ifdef MCM_SKIP_ZERO_EN
  // All three constants viewed as one flat bit string: position ci*CW + bi.
  localparam logic [3*CW-1:0] KALL = {K2, K1, K0};

  // Priority encoder: lowest set bit of the flat constant string at or above
  // 'from', or -1 when nothing remains. Crossing into a higher constant skips
  // zero constants entirely.
  function automatic int next_set(input int from);
    int r;
    r = -1;
    for (int p = 3*CW-1; p >= 0; p--) begin
      if (p >= from && KALL[p]) r = p;
    end
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef MCM_SKIP_ZERO_EN
    int nxt;
    nxt = -1;
`endif
    // NOTE: every signal gets a hold default first so no path leaves a latch.
    state_d = state_q;
    xr_d    = xr_q;
    ci_d    = ci_q;
    bi_d    = bi_q;
    y_d     = y_q;
    z_d     = z_q;
    w_d     = w_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          xr_d    = x;
          y_d     = '0;
          z_d     = '0;
          w_d     = '0;
          ci_d    = '0;
          bi_d    = '0;
          state_d = RUN;
`ifdef MCM_SKIP_ZERO_EN
          nxt = next_set(0);
          if (nxt < 0) begin
            state_d = DONE;
          end else begin
            ci_d = CIW'(nxt / CW);
            bi_d = SW'(nxt % CW);
          end
`endif
        end
      end

      RUN: begin
        if (bit_set) begin
          case (ci_q)
            2'd0:    y_d = acc_sum;
            2'd1:    z_d = acc_sum;
            default: w_d = acc_sum;
          endcase
        end
`ifdef MCM_SKIP_ZERO_EN
        nxt = next_set(int'(ci_q) * CW + int'(bi_q) + 1);
        if (nxt < 0) begin
          state_d = DONE;
          ci_d    = '0;
          bi_d    = '0;
        end else begin
          ci_d = CIW'(nxt / CW);
          bi_d = SW'(nxt % CW);
        end
`else
        if (bi_q == SW'(CW-1)) begin
          bi_d = '0;
          if (ci_q == CIW'(2)) begin
            state_d = DONE;
            ci_d    = '0;
          end else begin
            ci_d = ci_q + CIW'(1);
          end
        end else begin
          bi_d = bi_q + SW'(1);
        end
`endif
      end

      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered handshake outputs. out_valid rises one cycle after DONE is
  // entered and clears on the same edge that takes the FSM back to IDLE.
  always_comb begin
    out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the accumulators drive y/z/w directly and must read zero after
      // reset, so they are reset along with the control state.
      state_q     <= IDLE;
      xr_q        <= '0;
      ci_q        <= '0;
      bi_q        <= '0;
      y_q         <= '0;
      z_q         <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      xr_q        <= xr_d;
      ci_q        <= ci_d;
      bi_q        <= bi_d;
      y_q         <= y_d;
      z_q         <= z_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign y         = y_q;
  assign z         = z_q;
  assign w         = w_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mcm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mcm_seq_ctrl
// Self-checking bench for mcm_seq_ctrl. Two instances: the default constants
// (9, 23, 81) and an override (0, 1, 255). A fixed vector table, hand-written
// multi-cycle sequences (reset abort, back-to-back, DONE stall) and random
// transactions checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mcm_seq_ctrl;

  localparam logic [7:0] A_C0 = 8'd9;
  localparam logic [7:0] A_C1 = 8'd23;
  localparam logic [7:0] A_C2 = 8'd81;
  localparam logic [7:0] B_C0 = 8'd0;
  localparam logic [7:0] B_C1 = 8'd1;
  localparam logic [7:0] B_C2 = 8'd255;

  logic        clk;
  logic        rst;
  logic        iv;
  logic        or_r;
  logic        sel;
  logic [31:0] xx;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [31:0] a_y, a_z, a_w;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [31:0] b_y, b_z, b_w;

  logic        obs_in_ready, obs_valid, obs_busy;
  logic [31:0] obs_y, obs_z, obs_w;

  int n_cmp  = 0;
  int n_fail = 0;

  mcm_seq_ctrl #(.W(32), .CW(8), .C0(9), .C1(23), .C2(81)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv & ~sel),
    .in_ready  (a_in_ready),
    .x         (xx),
    .out_valid (a_out_valid),
    .out_ready (or_r & ~sel),
    .y         (a_y),
    .z         (a_z),
    .w         (a_w),
    .busy      (a_busy)
  );

  mcm_seq_ctrl #(.W(32), .CW(8), .C0(0), .C1(1), .C2(255)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv & sel),
    .in_ready  (b_in_ready),
    .x         (xx),
    .out_valid (b_out_valid),
    .out_ready (or_r & sel),
    .y         (b_y),
    .z         (b_z),
    .w         (b_w),
    .busy      (b_busy)
  );

  assign obs_in_ready = sel ? b_in_ready  : a_in_ready;
  assign obs_valid    = sel ? b_out_valid : a_out_valid;
  assign obs_busy     = sel ? b_busy      : a_busy;
  assign obs_y        = sel ? b_y         : a_y;
  assign obs_z        = sel ? b_z         : a_z;
  assign obs_w        = sel ? b_w         : a_w;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mul(input logic [31:0] xv, input logic [7:0] c);
    return xv * {24'd0, c};
  endfunction

  // Edges from accept until out_valid is first seen high.
  function automatic int lat_of(input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2);
`ifdef MCM_SKIP_ZERO_EN
    return $countones(c0) + $countones(c1) + $countones(c2) + 1;
`else
    return 3 * 8 + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction on the selected instance. Inputs change #1 after a
  // clock edge; outputs are sampled at the same point.
  task automatic run_txn(input logic [31:0] xv, input int hold, input bit keep_iv,
                         input logic [31:0] x_after, input int exp_lat,
                         input string tag, output logic [31:0] ry,
                         output logic [31:0] rz, output logic [31:0] rw);
    int cnt;
    int lat;
    bit ok;
    xx   = xv;
    iv   = 1'b1;
    or_r = 1'b0;
    cnt  = 0;
    while (!obs_in_ready && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, " in_ready before accept"}, obs_in_ready, 1);
    @(posedge clk); #1;
    xx  = x_after;
    iv  = keep_iv;
    lat = 0;
    ok  = 1'b1;
    while (!obs_valid && lat < 200) begin
      if (obs_in_ready !== 1'b0 || obs_busy !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " in_ready low/busy high while running"}, ok, 1);
    ry = obs_y;
    rz = obs_z;
    rw = obs_w;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      iv = (i % 2 == 0) | keep_iv;
      @(posedge clk); #1;
      if (obs_valid !== 1'b1 || obs_in_ready !== 1'b0 ||
          obs_y !== ry || obs_z !== rz || obs_w !== rw) ok = 1'b0;
    end
    if (hold > 0) check({tag, " stable while stalled"}, ok, 1);
    iv   = keep_iv;
    or_r = 1'b1;
    @(posedge clk); #1;
    or_r = 1'b0;
    check({tag, " out_valid drops after handshake"}, obs_valid, 0);
    if (!keep_iv) check({tag, " idle after handshake"}, {obs_busy, obs_in_ready}, 2'b01);
  endtask

  typedef struct {
    logic [31:0] x;
    int          hold;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] w;
  } vec_t;

  vec_t tbl[3];

  initial begin
    logic [31:0] ry, rz, rw, rx;
    int          hold;

    tbl[0] = '{x: 32'h0000_0001, hold: 0, y: 32'd9,         z: 32'd23,        w: 32'd81};
    tbl[1] = '{x: 32'hFFFF_FFFF, hold: 1, y: 32'hFFFF_FFF7, z: 32'hFFFF_FFE9, w: 32'hFFFF_FFAF};
    tbl[2] = '{x: 32'h1234_5678, hold: 5, y: 32'hA3D7_0A38, z: 32'hA2B3_C4C8, w: 32'hC28F_5BF8};

    rst  = 1'b1;
    iv   = 1'b0;
    or_r = 1'b0;
    sel  = 1'b0;
    xx   = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("reset in_ready",  a_in_ready,  1);
    check("reset out_valid", a_out_valid, 0);
    check("reset busy",      a_busy,      0);
    check("reset y", a_y, 0);
    check("reset z", a_z, 0);
    check("reset w", a_w, 0);
    check("reset b busy/in_ready", {b_busy, b_in_ready}, 2'b01);

    // Table-driven vectors on the default instance
    for (int i = 0; i < 3; i++) begin
      run_txn(tbl[i].x, tbl[i].hold, 1'b0, 32'h5555_AAAA,
              lat_of(A_C0, A_C1, A_C2), $sformatf("tbl%0d", i), ry, rz, rw);
      check($sformatf("tbl%0d y", i), ry, tbl[i].y);
      check($sformatf("tbl%0d z", i), rz, tbl[i].z);
      check($sformatf("tbl%0d w", i), rw, tbl[i].w);
    end

    // Reset in the 4th RUN cycle aborts the transaction
    xx = 32'd7;
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort out_valid", a_out_valid, 0);
    check("abort y/z/w zero", {a_y, a_z, a_w}, 96'd0);
    check("abort idle", {a_busy, a_in_ready}, 2'b01);
    run_txn(32'd3, 0, 1'b0, 32'd0, lat_of(A_C0, A_C1, A_C2), "after_abort", ry, rz, rw);
    check("after_abort y", ry, 32'd27);
    check("after_abort z", rz, 32'd69);
    check("after_abort w", rw, 32'd243);

    // Back-to-back with in_valid held; x changes mid-run must not leak in
    run_txn(32'd2, 0, 1'b1, 32'd5, lat_of(A_C0, A_C1, A_C2), "b2b_first", ry, rz, rw);
    check("b2b_first y", ry, 32'd18);
    check("b2b_first z", rz, 32'd46);
    check("b2b_first w", rw, 32'd162);
    run_txn(32'd5, 0, 1'b0, 32'd0, lat_of(A_C0, A_C1, A_C2), "b2b_second", ry, rz, rw);
    check("b2b_second y", ry, 32'd45);
    check("b2b_second z", rz, 32'd115);
    check("b2b_second w", rw, 32'd405);

    // Random transactions on the default instance
    for (int i = 0; i < 16; i++) begin
      rx   = $urandom;
      hold = $urandom_range(0, 2);
      run_txn(rx, hold, 1'b0, $urandom, lat_of(A_C0, A_C1, A_C2),
              $sformatf("rndA%0d", i), ry, rz, rw);
      check($sformatf("rndA%0d y", i), ry, mul(rx, A_C0));
      check($sformatf("rndA%0d z", i), rz, mul(rx, A_C1));
      check($sformatf("rndA%0d w", i), rw, mul(rx, A_C2));
    end

    // Override instance: zero constant and all-ones constant
    sel = 1'b1;
    run_txn(32'h0000_0100, 0, 1'b0, 32'd0, lat_of(B_C0, B_C1, B_C2), "ovr", ry, rz, rw);
    check("ovr y", ry, 32'd0);
    check("ovr z", rz, 32'h0000_0100);
    check("ovr w", rw, 32'h0000_FF00);
    for (int i = 0; i < 6; i++) begin
      rx = $urandom;
      run_txn(rx, 1, 1'b0, 32'd0, lat_of(B_C0, B_C1, B_C2),
              $sformatf("rndB%0d", i), ry, rz, rw);
      check($sformatf("rndB%0d y", i), ry, mul(rx, B_C0));
      check($sformatf("rndB%0d z", i), rz, mul(rx, B_C1));
      check($sformatf("rndB%0d w", i), rw, mul(rx, B_C2));
    end
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
